// File: rtl/uart_rx_deframer.sv
// Purpose : 8N1 UART receiver. Recovers bytes by mid-bit sampling and queues them
//           in a small FIFO whose head is offered on a valid/ready interface.
// Latency : start-bit falling edge to rx_valid = 2 (sync) + 9.5*CLK_DIV + 1 cycles.
// Backpr. : rx_ready low lets the FIFO fill; a byte completing while full is dropped
//           and flags overrun (unless a pop happens in the same cycle).
// Ports   : wb_clk_i/wb_rst_i  clock, synchronous active-high reset
//           rx                 asynchronous serial input, idle high
//           rx_data/rx_valid   FIFO head byte and non-empty flag; rx_ready pops head
//           fifo_count         bytes buffered
//           frame_err/overrun  sticky error flags, cleared by err_clr
module uart_rx_deframer #(
   parameter int CLK_DIV = 4340,
   parameter int DEPTH   = 8
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   input  logic                   rx,
   output logic [7:0]             rx_data,
   output logic                   rx_valid,
   input  logic                   rx_ready,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   frame_err,
   output logic                   overrun,
   input  logic                   err_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2 - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
   localparam logic [AW:0]   CNT1     = (AW + 1)'(1);
   localparam logic [AW-1:0] PTR1     = AW'(1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

   // Two-flop synchronizer; resets to the idle (high) line level so that
   // leaving reset never looks like a start bit.
   logic rx_meta, rx_s;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // Framing FSM
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          push, ferr_set;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shreg_d  = shreg_q;
      push     = 1'b0;
      ferr_set = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = S_START;
         end
         S_START: begin
            // Half a bit in: re-check the start bit to reject glitches and
            // move the sampling phase to mid-bit for the rest of the frame.
            if (cnt_q == CNT_HALF) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = rx_s ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               shreg_d = {rx_s, shreg_q[7:1]};   // LSB arrives first
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  push    = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ferr_set = 1'b1;
                  state_d  = S_BREAK;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_BREAK: begin
            // A line held low must return high before a new frame is hunted,
            // so a break produces a single frame error.
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Receive FIFO
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          full, pop, wr_en, ovr_set;

   assign full     = (count_q == FULL_CNT);
   assign rx_valid = (count_q != '0);
   assign pop      = rx_valid && rx_ready;
   // When full, a same-cycle pop frees the slot the push needs.
   assign wr_en    = push && (!full || pop);
   assign ovr_set  = push && full && !pop;

   always_ff @(posedge wb_clk_i) begin
      if (wr_en) mem[wr_ptr_q] <= shreg_q;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + PTR1;
         if (pop)   rd_ptr_q <= rd_ptr_q + PTR1;
         case ({wr_en, pop})
            2'b10:   count_q <= count_q + CNT1;
            2'b01:   count_q <= count_q - CNT1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Head is forced to zero when empty so stale entries never show.
   assign rx_data    = rx_valid ? mem[rd_ptr_q] : 8'h00;
   assign fifo_count = count_q;

   // Sticky flags; clear wins over a coincident set.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (err_clr)       frame_err <= 1'b0;
         else if (ferr_set) frame_err <= 1'b1;
         if (err_clr)       overrun   <= 1'b0;
         else if (ovr_set)  overrun   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer at 16 clocks per bit, 8-entry FIFO.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_rx_deframer;

   localparam int CLK_DIV = 16;
   localparam int DEPTH   = 8;
   localparam int FRAME   = 10 * CLK_DIV;

   logic       clk;
   logic       rst;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [3:0] fifo_count;
   logic       frame_err;
   logic       overrun;
   logic       err_clr;

   int n_vec  = 0;
   int n_miss = 0;

   uart_rx_deframer #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH)) dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .rx         (rx),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .fifo_count (fifo_count),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .err_clr    (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives the first ncyc cycles of a start/data/stop frame; rx is left at
   // the last driven level.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int ncyc);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      for (int c = 0; c < ncyc; c++) begin
         rx = fr[c / CLK_DIV];
         @(negedge clk);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_frame(b, 1'b1, FRAME);
      idle(2);
   endtask

   task automatic pop_one();
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   task automatic clr_err();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      rx       = 1'b1;
      rx_ready = 1'b0;
      err_clr  = 1'b0;
      idle(3);
      rst = 1'b0;
      idle(2);

      // Reset state
      check("rst_valid", rx_valid, 0);
      check("rst_data", rx_data, 8'h00);
      check("rst_count", fifo_count, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_ovr", overrun, 0);

      // 1: single byte
      send_byte(8'hA5);
      idle(2);
      check("t1_valid", rx_valid, 1);
      check("t1_data", rx_data, 8'hA5);
      check("t1_count", fifo_count, 1);
      check("t1_ferr", frame_err, 0);
      check("t1_ovr", overrun, 0);
      pop_one();
      check("t1_pop_count", fifo_count, 0);
      check("t1_pop_valid", rx_valid, 0);

      // 2: short glitch is not a start bit
      rx = 1'b0;
      idle(5);
      rx = 1'b1;
      idle(40);
      check("t2_count", fifo_count, 0);
      check("t2_valid", rx_valid, 0);
      check("t2_ferr", frame_err, 0);

      // 3: bad stop bit followed by a held-low line, then a good byte
      send_frame(8'h3C, 1'b0, FRAME);
      idle(40);
      rx = 1'b1;
      idle(20);
      check("t3_ferr_set", frame_err, 1);
      check("t3_count_bad", fifo_count, 0);
      send_byte(8'h55);
      idle(2);
      check("t3_count", fifo_count, 1);
      check("t3_data", rx_data, 8'h55);
      check("t3_ferr_hold", frame_err, 1);
      clr_err();
      check("t3_ferr_clr", frame_err, 0);
      pop_one();
      check("t3_empty", rx_valid, 0);

      // 4: overrun with nobody reading
      for (int i = 1; i <= 9; i++) send_byte(8'(i));
      idle(2);
      check("t4_count", fifo_count, 8);
      check("t4_ovr", overrun, 1);
      check("t4_ferr", frame_err, 0);
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("t4_pop%0d", i), rx_data, 32'(i));
         pop_one();
      end
      check("t4_empty", rx_valid, 0);
      check("t4_ovr_hold", overrun, 1);
      clr_err();
      check("t4_ovr_clr", overrun, 0);

      // 5: full FIFO, pop exactly on the push cycle of a 9th byte.
      // Push lands on the 155th rising edge after the start bit is driven.
      for (int i = 0; i < 8; i++) send_byte(8'(8'h11 + i));
      check("t5_full", fifo_count, 8);
      fork
         send_frame(8'h19, 1'b1, FRAME);
         begin
            idle(154);
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
         end
      join
      idle(4);
      check("t5_count", fifo_count, 8);
      check("t5_ovr", overrun, 0);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("t5_pop%0d", i), rx_data, 32'(8'h12 + i));
         pop_one();
      end
      check("t5_empty", rx_valid, 0);

      // 6: reset mid-DATA discards the partial byte and buffered data
      send_byte(8'h42);
      check("t6_pre", fifo_count, 1);
      send_frame(8'h77, 1'b1, 60);
      rx  = 1'b1;
      rst = 1'b1;
      idle(3);
      rst = 1'b0;
      idle(4);
      check("t6_rst_count", fifo_count, 0);
      check("t6_rst_valid", rx_valid, 0);
      idle(FRAME);
      check("t6_no_ghost", fifo_count, 0);
      send_byte(8'hC3);
      idle(2);
      check("t6_count", fifo_count, 1);
      check("t6_data", rx_data, 8'hC3);
      check("t6_ferr", frame_err, 0);
      pop_one();
      check("t6_empty", rx_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
